// File: rtl/onewire_pkg.sv
`default_nettype none
// onewire_pkg: responder state encoding, default bus timings and microsecond-to-cycle helper.
package onewire_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ = 10_000_000;
  localparam int unsigned DEF_T_RST_US    = 480;
  localparam int unsigned DEF_T_PDH_US    = 30;
  localparam int unsigned DEF_T_PDL_US    = 120;
  localparam int unsigned DEF_T_SAMPLE_US = 30;
  localparam int unsigned DEF_T_RDRV_US   = 30;

  typedef logic [2:0] ow_rsp_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SLOT_LOW  = 3'd1;
  localparam logic [2:0] ST_SLOT_RD   = 3'd2;
  localparam logic [2:0] ST_SLOT_END  = 3'd3;
  localparam logic [2:0] ST_RST_LOW   = 3'd4;
  localparam logic [2:0] ST_PRES_WAIT = 3'd5;
  localparam logic [2:0] ST_PRES_DRV  = 3'd6;
  localparam logic [2:0] ST_PRES_END  = 3'd7;

  // 64-bit product: 480 us at tens of MHz overflows 32 bits.
  function automatic int unsigned us2cyc(input int unsigned us, input int unsigned freq_hz);
    return 32'((64'(us) * 64'(freq_hz)) / 64'd1_000_000);
  endfunction

  localparam int unsigned DEF_CNT_W = $clog2(us2cyc(DEF_T_RST_US, DEF_CLK_FREQ_HZ) + 1);

endpackage
`default_nettype wire

// File: rtl/onewire_sync_edge.sv
`default_nettype none
// onewire_sync_edge: 2-flop synchronizer for an idle-high line with registered fall/rise pulses.
module onewire_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta;

  // Pulses are aligned with the cycle in which level first shows the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      level <= 1'b1;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      fall  <= level & ~meta;
      rise  <= ~level & meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/onewire_responder.sv
`default_nettype none
// onewire_responder: 1-Wire slave with reset/presence handling, LSB-first write and read slots,
// and a byte-wide valid/ready user interface.
module onewire_responder
  import onewire_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned T_RST_US    = DEF_T_RST_US,
  parameter int unsigned T_PDH_US    = DEF_T_PDH_US,
  parameter int unsigned T_PDL_US    = DEF_T_PDL_US,
  parameter int unsigned T_SAMPLE_US = DEF_T_SAMPLE_US,
  parameter int unsigned T_RDRV_US   = DEF_T_RDRV_US
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ow_i,
  output logic       ow_oe,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  input  logic [7:0] tx_dat,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       bus_rst,
  output logic       busy
);

  localparam int unsigned C_RST_I = us2cyc(T_RST_US, CLK_FREQ_HZ);
  localparam int unsigned CNT_W   = $clog2(C_RST_I + 1);

  localparam logic [CNT_W-1:0] C_RST    = CNT_W'(C_RST_I);
  localparam logic [CNT_W-1:0] C_SAMPLE = CNT_W'(us2cyc(T_SAMPLE_US, CLK_FREQ_HZ));
  localparam logic [CNT_W-1:0] C_RDRV   = CNT_W'(us2cyc(T_RDRV_US, CLK_FREQ_HZ));
  localparam logic [CNT_W-1:0] C_PDH_M1 = CNT_W'(us2cyc(T_PDH_US, CLK_FREQ_HZ) - 1);
  localparam logic [CNT_W-1:0] C_PDL_M1 = CNT_W'(us2cyc(T_PDL_US, CLK_FREQ_HZ) - 1);

  ow_rsp_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_sh;
  logic [7:0]       tx_sh;
  logic             tx_loaded;
  logic             ow_line;
  logic             line_fall;
  logic             line_rise;

  onewire_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ow_i),
    .level (ow_line),
    .fall  (line_fall),
    .rise  (line_rise)
  );

  assign tx_rdy = ~rst & (state == ST_IDLE) & ~tx_loaded & ow_line;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      rx_sh     <= 8'h00;
      tx_sh     <= 8'h00;
      tx_loaded <= 1'b0;
      ow_oe     <= 1'b0;
      rx_dat    <= 8'h00;
      rx_vld    <= 1'b0;
      bus_rst   <= 1'b0;
    end else begin
      rx_vld  <= 1'b0;
      bus_rst <= 1'b0;

      if (tx_vld && tx_rdy) begin
        tx_sh     <= tx_dat;
        tx_loaded <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (line_fall) begin
            // The edge cycle itself is cycle 0, so the counter starts at 1 here.
            cnt <= CNT_W'(1);
            if (tx_loaded) begin
              state <= ST_SLOT_RD;
              ow_oe <= ~tx_sh[0];
            end else begin
              state <= ST_SLOT_LOW;
            end
          end
        end

        ST_SLOT_LOW: begin
          cnt <= cnt + 1'b1;
          if (cnt == C_SAMPLE) begin
            rx_sh   <= {ow_line, rx_sh[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= ST_SLOT_END;
          end
        end

        ST_SLOT_RD: begin
          cnt <= cnt + 1'b1;
          if (cnt == C_RDRV) begin
            ow_oe   <= 1'b0;
            tx_sh   <= {1'b0, tx_sh[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            cnt     <= '0;
            state   <= ST_SLOT_END;
          end
        end

        ST_SLOT_END: begin
          // bit_cnt wraps to 0 exactly when the eighth slot of a byte has finished.
          if (ow_line) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (bit_cnt == 3'd0) begin
              if (tx_loaded) begin
                tx_loaded <= 1'b0;
              end else begin
                rx_dat <= rx_sh;
                rx_vld <= 1'b1;
              end
            end
          end else if (cnt == C_RST) begin
            state     <= ST_RST_LOW;
            bit_cnt   <= 3'd0;
            tx_loaded <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RST_LOW: begin
          if (line_rise) begin
            bus_rst <= 1'b1;
            cnt     <= CNT_W'(1);
            state   <= ST_PRES_WAIT;
          end
        end

        ST_PRES_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == C_PDH_M1) begin
            ow_oe <= 1'b1;
            cnt   <= '0;
            state <= ST_PRES_DRV;
          end
        end

        ST_PRES_DRV: begin
          cnt <= cnt + 1'b1;
          if (cnt == C_PDL_M1) begin
            ow_oe <= 1'b0;
            cnt   <= '0;
            state <= ST_PRES_END;
          end
        end

        ST_PRES_END: begin
          if (ow_line) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
